mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage load/store unit for the pipelined MIPS datapath. It sits between the EX/MEM pipeline register and the MEM/WB register. It turns byte, halfword and word loads and stores into byte-lane requests on a req/ack data-memory port, and stalls the pipeline until the memory acknowledges. It delivers aligned, extended load data to MEM/WB's ReadDataIn.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data width; fixed at 32 (four byte lanes).

Ports:
- Clk  in  1  pipeline clock; all state on rising edge.
- Rst  in  1  synchronous, active-high reset.
- MemReadIn  in  1  load in EX/MEM.
- MemWriteIn  in  1  store in EX/MEM.
- SizeIn  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- LoadExtendedIn  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- AddressIn  in  ADDR_W  ALU result (byte address).
- WriteDataIn  in  32  store data, right-justified.
- DmemReq  out  1  memory request.
- DmemWe  out  1  1 = write.
- DmemAddr  out  ADDR_W  word address; bits [1:0] are always 0.
- DmemWData  out  32  lane-positioned store data.
- DmemByteEn  out  4  byte-lane enables.
- DmemAck  in  1  request complete; read data valid this cycle.
- DmemRData  in  32  read word.
- ReadDataOut  out  32  extended load data to MEM/WB.
- Stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- MemBubble  out  1  the MEM/WB write this cycle must carry RegWrite=0.
- AlignErr  out  1  misaligned access (see Configuration).

## Operation
- Lanes are little-endian: byte k is data[8k+7:8k] and is selected by AddressIn[1:0]=k.
- Store byte:
  - WriteDataIn[7:0] is replicated to all four lanes.
  - DmemByteEn = 1<<addr[1:0].
- Store half:
  - WriteDataIn[15:0] is replicated to both halves.
  - DmemByteEn = 0011 when addr[1]=0, 1100 when addr[1]=1.
- Store word: DmemByteEn = 1111.
- Loads:
  - DmemByteEn follows the same rules as stores.
  - The selected byte or half of DmemRData is shifted to bit 0 and extended per LoadExtendedIn.
  - The extension setting is latched at request time.
- MemReadIn and MemWriteIn both high: treated as a store.
- State machine:
  - IDLE: no access → stay. Access → Stall=1; latch address, size, extension mode, data and We; go to REQ.
  - REQ: DmemReq=1, Stall=1. Address, data, enables and We are held stable until DmemAck. On DmemAck, latch the extended load data into LDBUF and go to DONE.
  - DONE: Stall=0; ReadDataOut=LDBUF; always go to IDLE. The access still visible in EX/MEM during DONE is the completed one and is never reissued.
- MemBubble=1 whenever Stall=1, so the frozen instruction does not write back twice.
- DmemAck outside REQ is ignored.
- ReadDataOut holds LDBUF until the next load completes; stores leave it unchanged.

## Timing
- Reset values: state IDLE, LDBUF=0. All outputs are 0: Req, We, Addr, WData, ByteEn, ReadDataOut, Stall, MemBubble, AlignErr.
- Stall is combinational in IDLE (same cycle as the access arrives) and registered-state based in REQ.
- Minimum latency with DmemAck in the first REQ cycle: 3 cycles (IDLE-detect, REQ, DONE), i.e. 2 stall cycles.
- Each extra wait cycle adds one stall cycle.
- Back-to-back accesses: the second access arrives in IDLE in the cycle after DONE; there is no dead cycle beyond DONE.
- Rst during REQ:
  - The next state is IDLE and DmemReq drops after that edge.
  - LDBUF is cleared.
  - An Ack arriving after reset is ignored.

## Configuration
- ALIGN_CHECK_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no request.
  - AlignErr pulses for one cycle and Stall stays 0.
  - ReadDataOut is 0 in the following cycle and LDBUF is cleared.
- ALIGN_CHECK_EN undefined:
  - AlignErr is tied to 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0] (forced alignment).

## Structure
- Shared package mips_mem_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - the state enum IDLE/REQ/DONE;
  - the lane-count constant.
- One combinational sub-module, load_align: inputs word, addr[1:0], size and extend; output is the 32-bit result.

## Test plan
- Word load at 0x100, Ack after 2 wait cycles, DmemRData=0xDEADBEEF:
  - DmemAddr=0x100, ByteEn=1111;
  - Stall high for 4 cycles;
  - ReadDataOut=0xDEADBEEF in DONE.
- Signed byte load at 0x103, DmemRData=0x80112233 → ByteEn=1000, ReadDataOut=0xFFFFFF80. Unsigned → 0x00000080.
- Half store at 0x202, WriteDataIn=0x0000ABCD → DmemAddr=0x200, ByteEn=1100, WData=0xABCDABCD, We=1.
- Two consecutive loads, each acked immediately → exactly 2 requests, Stall pattern 1,1,0,1,1,0, MemBubble equal to Stall.
- Rst asserted in REQ with Ack arriving one cycle later → DmemReq=0 after the reset edge, state IDLE, ReadDataOut=0, no DONE cycle.
- With ALIGN_CHECK_EN, word load at 0x101 → no DmemReq, AlignErr=1 for one cycle, Stall=0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size
// encodings, FSM state type, lane count and lane-enable helpers.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    // Size code 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_WORD : size;
    endfunction

    // Little-endian byte-lane enables; sub-lane address bits below the
    // access size are ignored, which gives forced alignment.
    function automatic logic [LANES-1:0] lane_enables(input logic [1:0] size,
                                                      input logic [1:0] lane);
        logic [LANES-1:0] be;
        case (norm_size(size))
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks the addressed byte or halfword out of a read
// word, moves it to bit 0 and zero- or sign-extends it.
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        extend,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane select followed by extension.
    always_comb begin
        case (addr)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = addr[1] ? word[31:16] : word[15:0];
        case (norm_size(size))
            SIZE_BYTE: result = {{24{extend & sel_byte[7]}}, sel_byte};
            SIZE_HALF: result = {{16{extend & sel_half[15]}}, sel_half};
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: converts byte/half/word accesses into a
// req/ack data-memory transaction, stalls the pipeline until ack and
// returns aligned, extended load data.
// Optional build macro ALIGN_CHECK_EN: misaligned half/word accesses are
// rejected with an AlignErr pulse instead of being force-aligned.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              MemReadIn,
    input  logic              MemWriteIn,
    input  logic [1:0]        SizeIn,
    input  logic              LoadExtendedIn,
    input  logic [ADDR_W-1:0] AddressIn,
    input  logic [DATA_W-1:0] WriteDataIn,
    output logic              DmemReq,
    output logic              DmemWe,
    output logic [ADDR_W-1:0] DmemAddr,
    output logic [DATA_W-1:0] DmemWData,
    output logic [LANES-1:0]  DmemByteEn,
    input  logic              DmemAck,
    input  logic [DATA_W-1:0] DmemRData,
    output logic [DATA_W-1:0] ReadDataOut,
    output logic              Stall,
    output logic              MemBubble,
    output logic              AlignErr
);

    state_t            state_q, state_d;
    logic              access, misaligned, start, align_err;
    logic [1:0]        size_n;
    logic [DATA_W-1:0] store_data;
    logic [1:0]        lane_q, size_q;
    logic              ext_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, ldbuf_q, load_data;
    logic [LANES-1:0]  be_q;

    // A simultaneous read+write request is handled as a store (we = MemWriteIn).
    assign access = MemReadIn | MemWriteIn;
    assign size_n = norm_size(SizeIn);

`ifdef ALIGN_CHECK_EN
    assign misaligned = ((size_n == SIZE_HALF) && AddressIn[0]) ||
                        ((size_n == SIZE_WORD) && (AddressIn[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign start     = (state_q == IDLE) && access && !misaligned && !Rst;
    assign align_err = (state_q == IDLE) && access &&  misaligned && !Rst;

    // Store data replicated across all lanes it could land in.
    always_comb begin
        case (size_n)
            SIZE_BYTE: store_data = {LANES{WriteDataIn[7:0]}};
            SIZE_HALF: store_data = {2{WriteDataIn[15:0]}};
            default:   store_data = WriteDataIn;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; DONE never reissues the access still in EX/MEM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (DmemAck) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; Stall is combinational on the arriving access in IDLE.
    always_comb begin
        DmemReq   = (state_q == REQ);
        Stall     = start || (state_q == REQ);
        MemBubble = Stall;
        AlignErr  = align_err;
    end

    // Request capture; held stable through REQ.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            lane_q  <= '0;
            size_q  <= SIZE_BYTE;
            ext_q   <= 1'b0;
        end else if (start) begin
            we_q    <= MemWriteIn;
            addr_q  <= {AddressIn[ADDR_W-1:2], 2'b00};
            wdata_q <= store_data;
            be_q    <= lane_enables(SizeIn, AddressIn[1:0]);
            lane_q  <= AddressIn[1:0];
            size_q  <= size_n;
            ext_q   <= LoadExtendedIn;
        end
    end

    assign DmemWe     = we_q;
    assign DmemAddr   = addr_q;
    assign DmemWData  = wdata_q;
    assign DmemByteEn = be_q;

    load_align u_load_align (
        .word   (DmemRData),
        .addr   (lane_q),
        .size   (size_q),
        .extend (ext_q),
        .result (load_data)
    );

    // Load buffer: updated only by a completed load, cleared by reset or
    // a rejected misaligned access.
    always_ff @(posedge Clk) begin
        if (Rst || align_err)
            ldbuf_q <= '0;
        else if ((state_q == REQ) && DmemAck && !we_q)
            ldbuf_q <= load_data;
    end

    assign ReadDataOut = ldbuf_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random
// accesses checked against an arithmetic model of the lane rules.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        MemReadIn = 1'b0;
    logic        MemWriteIn = 1'b0;
    logic [1:0]  SizeIn = 2'b00;
    logic        LoadExtendedIn = 1'b0;
    logic [31:0] AddressIn = '0;
    logic [31:0] WriteDataIn = '0;
    logic        DmemReq, DmemWe;
    logic [31:0] DmemAddr, DmemWData;
    logic [3:0]  DmemByteEn;
    logic        DmemAck = 1'b0;
    logic [31:0] DmemRData = '0;
    logic [31:0] ReadDataOut;
    logic        Stall, MemBubble, AlignErr;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_req_seen = 0;
    int unsigned n_req_exp = 0;
    int unsigned stall_seen = 0;
    logic [31:0] model_ldbuf = '0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .SizeIn(SizeIn), .LoadExtendedIn(LoadExtendedIn), .AddressIn(AddressIn),
        .WriteDataIn(WriteDataIn), .DmemReq(DmemReq), .DmemWe(DmemWe),
        .DmemAddr(DmemAddr), .DmemWData(DmemWData), .DmemByteEn(DmemByteEn),
        .DmemAck(DmemAck), .DmemRData(DmemRData), .ReadDataOut(ReadDataOut),
        .Stall(Stall), .MemBubble(MemBubble), .AlignErr(AlignErr)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (DmemReq && DmemAck) n_req_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle with no access; optionally drives a stray ack.
    task automatic idle(input logic stray_ack);
        MemReadIn = 1'b0; MemWriteIn = 1'b0; DmemAck = stray_ack;
        @(negedge Clk);
        check("idle_stall", Stall, 0);
        check("idle_req", DmemReq, 0);
        check("idle_rdata", ReadDataOut, model_ldbuf);
        @(posedge Clk); #1;
        DmemAck = 1'b0;
    endtask

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] size,
                             input logic ext, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int unsigned waits);
        int unsigned nbytes, first;
        logic [63:0] mask;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_load;
        logic        mis;

        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        first  = (int'(addr[1:0]) / nbytes) * nbytes;
        mask   = (64'd1 << (8 * nbytes)) - 64'd1;
        exp_be = 4'(((1 << nbytes) - 1) << first);
        exp_wd = '0;
        for (int i = 0; i < 4 / int'(nbytes); i++)
            exp_wd |= 32'((64'(wdata) & mask) << (8 * nbytes * i));
        exp_load = 32'((64'(rdata) >> (8 * first)) & mask);
        if (ext && nbytes < 4 && exp_load[8 * nbytes - 1]) exp_load |= ~32'(mask);
`ifdef ALIGN_CHECK_EN
        mis = (int'(addr[1:0]) % nbytes) != 0;
`else
        mis = 1'b0;
`endif

        MemReadIn = rd; MemWriteIn = wr; SizeIn = size; LoadExtendedIn = ext;
        AddressIn = addr; WriteDataIn = wdata; DmemRData = rdata; DmemAck = 1'b0;
        stall_seen = 0;

        if (mis) begin
            @(negedge Clk);
            check("align_err", AlignErr, 1);
            check("align_stall", Stall, 0);
            check("align_req", DmemReq, 0);
            @(posedge Clk); #1;
            MemReadIn = 1'b0; MemWriteIn = 1'b0;
            model_ldbuf = '0;
            @(negedge Clk);
            check("align_err_pulse", AlignErr, 0);
            check("align_rdata", ReadDataOut, 0);
            check("align_req2", DmemReq, 0);
            @(posedge Clk); #1;
            return;
        end

        @(negedge Clk);
        check("detect_stall", Stall, 1);
        check("detect_bubble", MemBubble, 1);
        check("detect_req", DmemReq, 0);
        stall_seen += int'(Stall);
        @(posedge Clk); #1;
        for (int unsigned w = 0; w <= waits; w++) begin
            @(negedge Clk);
            check("req", DmemReq, 1);
            check("req_stall", Stall, 1);
            check("req_bubble", MemBubble, 1);
            check("addr", DmemAddr, addr & 32'hFFFF_FFFC);
            check("byte_en", DmemByteEn, exp_be);
            check("we", DmemWe, wr);
            if (wr) check("wdata", DmemWData, exp_wd);
            stall_seen += int'(Stall);
            DmemAck = (w == waits);
            @(posedge Clk); #1;
        end
        DmemAck = 1'b0;
        n_req_exp++;
        if (!wr) model_ldbuf = exp_load;
        @(negedge Clk);
        check("done_stall", Stall, 0);
        check("done_bubble", MemBubble, 0);
        check("done_req", DmemReq, 0);
        check("done_rdata", ReadDataOut, model_ldbuf);
        stall_seen += int'(Stall);
        @(posedge Clk); #1;
    endtask

    initial begin
        // Reset state.
        @(posedge Clk); #1;
        @(negedge Clk);
        check("rst_req", DmemReq, 0);
        check("rst_we", DmemWe, 0);
        check("rst_addr", DmemAddr, 0);
        check("rst_wdata", DmemWData, 0);
        check("rst_be", DmemByteEn, 0);
        check("rst_rdata", ReadDataOut, 0);
        check("rst_stall", Stall, 0);
        check("rst_bubble", MemBubble, 0);
        check("rst_alignerr", AlignErr, 0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        idle(1'b0);

        // Word load, two wait cycles.
        do_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        check("word_stall_cycles", stall_seen, 4);
        check("word_load_value", ReadDataOut, 32'hDEADBEEF);
        idle(1'b0);

        // Byte loads at lane 3, signed then unsigned.
        do_access(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 0);
        check("sbyte_value", ReadDataOut, 32'hFFFFFF80);
        do_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80112233, 0);
        check("ubyte_value", ReadDataOut, 32'h00000080);

        // Half store: load buffer must stay untouched.
        do_access(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h55555555, 1);
        check("store_keeps_ldbuf", ReadDataOut, 32'h00000080);
        idle(1'b1);
        idle(1'b0);

        // Back-to-back loads acked immediately.
        do_access(1, 0, 2'b01, 1, 32'h400, 32'h0, 32'h1234F00D, 0);
        check("b2b_first_stalls", stall_seen, 2);
        do_access(1, 0, 2'b01, 1, 32'h402, 32'h0, 32'h8001F00D, 0);
        check("b2b_second_stalls", stall_seen, 2);
        check("b2b_value", ReadDataOut, 32'hFFFF8001);
        idle(1'b0);

        // Reset while waiting in REQ; late ack ignored.
        MemReadIn = 1'b1; SizeIn = 2'b10; AddressIn = 32'h300; DmemRData = 32'h12345678;
        @(posedge Clk); #1;
        @(negedge Clk);
        check("rstreq_req", DmemReq, 1);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0; MemReadIn = 1'b0; DmemAck = 1'b1;
        model_ldbuf = '0;
        @(negedge Clk);
        check("rstreq_req_drop", DmemReq, 0);
        check("rstreq_stall", Stall, 0);
        check("rstreq_rdata", ReadDataOut, 0);
        @(posedge Clk); #1;
        DmemAck = 1'b0;
        @(negedge Clk);
        check("rstreq_no_done_rdata", ReadDataOut, 0);
        check("rstreq_no_req", DmemReq, 0);
        @(posedge Clk); #1;

        // Misaligned word load.
        do_access(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'hCAFEF00D, 0);
        idle(1'b0);

        // Random accesses.
        for (int n = 0; n < 80; n++) begin
            int unsigned kind;
            logic rd, wr;
            kind = $urandom_range(0, 3);
            rd = (kind != 2);
            wr = (kind >= 2);
            do_access(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 32'hFFFF)), $urandom, $urandom,
                      $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
        end
        idle(1'b0);

        check("request_count", n_req_seen, n_req_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
